// File: rtl/mold_msg_framer.sv
// mold_msg_framer: re-frames the MoldUDP64 per-beat message stream for the ITCH
// decoder. It tracks the bytes remaining against the declared length, generates
// an explicit last-beat marker, latches the message type byte, and counts
// completed messages and framing errors.
module mold_msg_framer #(
    parameter int unsigned AXI_DATA_W = 64,
    parameter int unsigned AXI_KEEP_W = AXI_DATA_W / 8,
    parameter int unsigned ML_W       = 16,
    parameter int unsigned MSG_CNT_W  = 32,
    parameter int unsigned ERR_CNT_W  = 16
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  mold_msg_v_i,
    input  logic                  mold_msg_start_i,
    input  logic [ML_W-1:0]       mold_msg_len_i,
    input  logic [AXI_KEEP_W-1:0] mold_msg_mask_i,
    input  logic [AXI_DATA_W-1:0] mold_msg_data_i,
    output logic                  itch_v_o,
    output logic                  itch_start_o,
    output logic                  itch_last_o,
    output logic [AXI_KEEP_W-1:0] itch_mask_o,
    output logic [AXI_DATA_W-1:0] itch_data_o,
    output logic [7:0]            itch_type_o,
    output logic                  itch_err_o,
    output logic                  itch_trunc_o,
    output logic [MSG_CNT_W-1:0]  msg_cnt_o,
    output logic [ERR_CNT_W-1:0]  err_cnt_o
);

    localparam int unsigned PC_W  = $clog2(AXI_KEEP_W + 1);
    localparam int unsigned REM_W = ML_W + 1;
    localparam int unsigned ESUM_W = ERR_CNT_W + 2;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_IN_MSG = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [REM_W-1:0]        r_rem;

    logic [PC_W-1:0]         w_pc;
    logic [REM_W-1:0]        w_pc_ext;
    logic [REM_W-1:0]        w_len_ext;
    logic                    w_is_start;
    logic                    w_is_cont;
    logic                    w_is_orphan;
    logic                    w_start_bad;
    logic                    w_start_done;
    logic                    w_cont_done;
    logic                    w_cont_over;

    logic                    w_v;
    logic                    w_start;
    logic                    w_last;
    logic                    w_err;
    logic                    w_trunc;
    logic [AXI_KEEP_W-1:0]   w_mask;
    logic [AXI_DATA_W-1:0]   w_data;
    logic [7:0]              w_type;
    logic [REM_W-1:0]        w_rem;
    logic                    w_msg_inc;
    logic [1:0]              w_err_inc;
    logic [ESUM_W-1:0]       w_err_sum;
    logic [ERR_CNT_W-1:0]    w_err_cnt_nxt;

    // Byte count of the current beat (mask is contiguous, popcount is general).
    always_comb begin
        w_pc = '0;
        for (int i = 0; i < AXI_KEEP_W; i++) begin
            w_pc = w_pc + PC_W'(mold_msg_mask_i[i]);
        end
    end

    // Beat classification and length comparisons; all consumers gate on valid.
    always_comb begin
        w_pc_ext     = REM_W'(w_pc);
        w_len_ext    = REM_W'(mold_msg_len_i);
        w_is_start   = mold_msg_v_i & mold_msg_start_i;
        w_is_cont    = mold_msg_v_i & ~mold_msg_start_i & (r_state == S_IN_MSG);
        w_is_orphan  = mold_msg_v_i & ~mold_msg_start_i & (r_state == S_IDLE);
        w_start_bad  = (mold_msg_len_i == '0) || (w_len_ext < w_pc_ext);
        w_start_done = (w_len_ext == w_pc_ext);
        w_cont_done  = (w_pc_ext == r_rem);
        w_cont_over  = (w_pc_ext > r_rem);
    end

    // State register.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic: a message closes on completion or on any length error.
    always_comb begin
        w_state_nxt = r_state;
        if (w_is_start) begin
            w_state_nxt = (w_start_bad || w_start_done) ? S_IDLE : S_IN_MSG;
        end else if (w_is_cont && (w_cont_done || w_cont_over)) begin
            w_state_nxt = S_IDLE;
        end
    end

    // Output and counter-update logic for the next registered beat.
    always_comb begin
        w_v       = 1'b0;
        w_start   = 1'b0;
        w_last    = 1'b0;
        w_err     = 1'b0;
        w_trunc   = 1'b0;
        w_mask    = itch_mask_o;
        w_data    = itch_data_o;
        w_type    = itch_type_o;
        w_rem     = r_rem;
        w_msg_inc = 1'b0;
        w_err_inc = 2'd0;
        if (w_is_start) begin
            w_v       = 1'b1;
            w_start   = 1'b1;
            w_mask    = mold_msg_mask_i;
            w_data    = mold_msg_data_i;
            w_type    = mold_msg_data_i[7:0];
            w_rem     = w_len_ext - w_pc_ext;
            w_trunc   = (r_state == S_IN_MSG);
            w_err_inc = {1'b0, w_trunc};
            if (w_start_bad) begin
                w_last    = 1'b1;
                w_err     = 1'b1;
                w_err_inc = w_err_inc + 2'd1;
            end else if (w_start_done) begin
                w_last    = 1'b1;
                w_msg_inc = 1'b1;
            end
        end else if (w_is_cont) begin
            w_v    = 1'b1;
            w_mask = mold_msg_mask_i;
            w_data = mold_msg_data_i;
            if (w_cont_over) begin
                w_last    = 1'b1;
                w_err     = 1'b1;
                w_err_inc = 2'd1;
            end else if (w_cont_done) begin
                w_last    = 1'b1;
                w_msg_inc = 1'b1;
            end else begin
                w_rem = r_rem - w_pc_ext;
            end
        end else if (w_is_orphan) begin
            w_err_inc = 2'd1;
        end
    end

    // Saturating error counter: up to two events can land in one cycle.
    always_comb begin
        w_err_sum = ESUM_W'(err_cnt_o) + ESUM_W'(w_err_inc);
        if (w_err_sum > ESUM_W'({ERR_CNT_W{1'b1}})) begin
            w_err_cnt_nxt = {ERR_CNT_W{1'b1}};
        end else begin
            w_err_cnt_nxt = ERR_CNT_W'(w_err_sum);
        end
    end

    // Registered outputs, remaining-byte counter and statistics.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            r_rem        <= '0;
            itch_v_o     <= 1'b0;
            itch_start_o <= 1'b0;
            itch_last_o  <= 1'b0;
            itch_err_o   <= 1'b0;
            itch_trunc_o <= 1'b0;
            itch_mask_o  <= '0;
            itch_data_o  <= '0;
            itch_type_o  <= '0;
            msg_cnt_o    <= '0;
            err_cnt_o    <= '0;
        end else begin
            r_rem        <= w_rem;
            itch_v_o     <= w_v;
            itch_start_o <= w_start;
            itch_last_o  <= w_last;
            itch_err_o   <= w_err;
            itch_trunc_o <= w_trunc;
            itch_mask_o  <= w_mask;
            itch_data_o  <= w_data;
            itch_type_o  <= w_type;
            msg_cnt_o    <= msg_cnt_o + MSG_CNT_W'(w_msg_inc);
            err_cnt_o    <= w_err_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_mold_msg_framer.sv
// Randomized bench for mold_msg_framer against a message-level reference model.
module tb_mold_msg_framer;

    localparam int unsigned DW  = 64;
    localparam int unsigned KW  = 8;
    localparam int unsigned MLW = 16;
    localparam int unsigned MCW = 32;
    localparam int unsigned ECW = 16;

    logic           clk = 1'b0;
    logic           nreset = 1'b1;
    logic           mold_msg_v_i = 1'b0;
    logic           mold_msg_start_i = 1'b0;
    logic [MLW-1:0] mold_msg_len_i = '0;
    logic [KW-1:0]  mold_msg_mask_i = '0;
    logic [DW-1:0]  mold_msg_data_i = '0;
    logic           itch_v_o, itch_start_o, itch_last_o, itch_err_o, itch_trunc_o;
    logic [KW-1:0]  itch_mask_o;
    logic [DW-1:0]  itch_data_o;
    logic [7:0]     itch_type_o;
    logic [MCW-1:0] msg_cnt_o;
    logic [ECW-1:0] err_cnt_o;

    always #5 clk = ~clk;

    mold_msg_framer dut (
        .clk              (clk),
        .nreset           (nreset),
        .mold_msg_v_i     (mold_msg_v_i),
        .mold_msg_start_i (mold_msg_start_i),
        .mold_msg_len_i   (mold_msg_len_i),
        .mold_msg_mask_i  (mold_msg_mask_i),
        .mold_msg_data_i  (mold_msg_data_i),
        .itch_v_o         (itch_v_o),
        .itch_start_o     (itch_start_o),
        .itch_last_o      (itch_last_o),
        .itch_mask_o      (itch_mask_o),
        .itch_data_o      (itch_data_o),
        .itch_type_o      (itch_type_o),
        .itch_err_o       (itch_err_o),
        .itch_trunc_o     (itch_trunc_o),
        .msg_cnt_o        (msg_cnt_o),
        .err_cnt_o        (err_cnt_o)
    );

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: message-level bookkeeping with plain integers.
    bit          m_in_msg;
    int          m_left;
    longint      m_msgs;
    longint      m_errs;
    bit          e_v, e_start, e_last, e_err, e_trunc;
    logic [7:0]  e_type;
    logic [KW-1:0] e_mask;
    logic [DW-1:0] e_data;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_in_msg = 0; m_left = 0; m_msgs = 0; m_errs = 0;
        e_v = 0; e_start = 0; e_last = 0; e_err = 0; e_trunc = 0;
        e_type = '0; e_mask = '0; e_data = '0;
    endtask

    task automatic compare_all(input string ctx);
        check({ctx, ".v"},     64'(itch_v_o),     64'(e_v));
        check({ctx, ".start"}, 64'(itch_start_o), 64'(e_start));
        check({ctx, ".last"},  64'(itch_last_o),  64'(e_last));
        check({ctx, ".err"},   64'(itch_err_o),   64'(e_err));
        check({ctx, ".trunc"}, 64'(itch_trunc_o), 64'(e_trunc));
        check({ctx, ".type"},  64'(itch_type_o),  64'(e_type));
        check({ctx, ".mask"},  64'(itch_mask_o),  64'(e_mask));
        check({ctx, ".data"},  itch_data_o,       e_data);
        check({ctx, ".msgs"},  64'(msg_cnt_o),    64'(MCW'(m_msgs)));
        check({ctx, ".errs"},  64'(err_cnt_o),    (m_errs > 65535) ? 64'd65535 : 64'(m_errs));
    endtask

    // Drive one beat, apply the message rules to the model, then compare.
    task automatic step(input string ctx, input bit v, input bit st, input int len,
                        input logic [KW-1:0] mask, input logic [DW-1:0] data);
        int pc;
        mold_msg_v_i     = v;
        mold_msg_start_i = st;
        mold_msg_len_i   = MLW'(len);
        mold_msg_mask_i  = mask;
        mold_msg_data_i  = data;
        @(posedge clk);
        pc = $countones(mask);
        e_v = 0; e_start = 0; e_last = 0; e_err = 0; e_trunc = 0;
        if (v && st) begin
            e_v = 1; e_start = 1; e_type = data[7:0]; e_mask = mask; e_data = data;
            if (m_in_msg) begin e_trunc = 1; m_errs++; end
            m_in_msg = 0;
            if (len == 0 || len < pc) begin e_last = 1; e_err = 1; m_errs++; end
            else if (len == pc) begin e_last = 1; m_msgs++; end
            else begin m_in_msg = 1; m_left = len - pc; end
        end else if (v && m_in_msg) begin
            e_v = 1; e_mask = mask; e_data = data;
            if (pc > m_left) begin e_last = 1; e_err = 1; m_errs++; m_in_msg = 0; end
            else if (pc == m_left) begin e_last = 1; m_msgs++; m_in_msg = 0; end
            else m_left = m_left - pc;
        end else if (v) begin
            m_errs++;
        end
        #1;
        compare_all(ctx);
    endtask

    function automatic logic [KW-1:0] kmask(input int k);
        logic [KW:0] t;
        t = (KW+1)'(1) << k;
        return KW'(t - 1);
    endfunction

    function automatic logic [DW-1:0] rdata();
        return {$urandom, $urandom};
    endfunction

    initial begin
        model_reset();
        #2 nreset = 1'b0;
        #1;
        check("rst.v", 64'(itch_v_o), 64'd0);
        check("rst.msgs", 64'(msg_cnt_o), 64'd0);
        check("rst.errs", 64'(err_cnt_o), 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) nreset = 1'b1;
        @(posedge clk); #1;

        // Nominal two-beat message
        step("nom1", 1, 1, 16, 8'hFF, 64'h0807060504030241);
        check("nom1.start_lit", 64'(itch_start_o), 64'd1);
        check("nom1.type_lit", 64'(itch_type_o), 64'h41);
        step("nom2", 1, 0, 0, 8'hFF, rdata());
        check("nom2.last_lit", 64'(itch_last_o), 64'd1);
        check("nom2.type_lit", 64'(itch_type_o), 64'h41);
        check("nom2.msgs_lit", 64'(msg_cnt_o), 64'd1);

        // Partial tail and single-beat message
        step("part1", 1, 1, 12, 8'hFF, rdata());
        step("part2", 1, 0, 0, 8'h0F, rdata());
        check("part2.mask_lit", 64'(itch_mask_o), 64'h0F);
        step("single", 1, 1, 3, 8'h07, rdata());
        check("single.msgs_lit", 64'(msg_cnt_o), 64'd3);

        // Overrun and zero-length
        step("ovr1", 1, 1, 10, 8'hFF, rdata());
        step("ovr2", 1, 0, 0, 8'hFF, rdata());
        check("ovr2.errs_lit", 64'(err_cnt_o), 64'd1);
        step("len0", 1, 1, 0, 8'hFF, rdata());
        check("len0.err_lit", 64'(itch_err_o), 64'd1);

        // Truncation by a new start
        step("tr1", 1, 1, 24, 8'hFF, rdata());
        step("tr2", 1, 0, 0, 8'hFF, rdata());
        step("tr3", 1, 1, 8, 8'hFF, rdata());
        check("tr3.trunc_lit", 64'(itch_trunc_o), 64'd1);
        check("tr3.errs_lit", 64'(err_cnt_o), 64'd3);
        check("tr3.msgs_lit", 64'(msg_cnt_o), 64'd4);

        // Orphan beat, then a message with idle gaps
        step("orph", 1, 0, 0, 8'hFF, rdata());
        step("gap1", 1, 1, 16, 8'hFF, 64'h41);
        repeat (3) step("gapi", 0, $urandom_range(0, 1) != 0, $urandom_range(0, 65535), KW'($urandom), rdata());
        step("gap2", 1, 0, 0, 8'hFF, rdata());
        check("gap2.last_lit", 64'(itch_last_o), 64'd1);
        check("gap2.msgs_lit", 64'(msg_cnt_o), 64'd5);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            bit v, st;
            int len;
            v   = $urandom_range(0, 3) != 0;
            st  = $urandom_range(0, 5) == 0;
            len = ($urandom_range(0, 19) == 0) ? int'($urandom_range(0, 65535)) : int'($urandom_range(0, 40));
            step("rnd", v, st, len, kmask($urandom_range(0, KW)), rdata());
        end

        // Reset in the middle of a message
        step("rm1", 1, 1, 16, 8'hFF, rdata());
        mold_msg_v_i = 1'b0;
        #2 nreset = 1'b0;
        #1;
        model_reset();
        compare_all("rstmid");
        @(negedge clk) nreset = 1'b1;
        step("rm_orph", 1, 0, 0, 8'hFF, rdata());
        check("rm_orph.errs_lit", 64'(err_cnt_o), 64'd1);

        // Drive the error counter into saturation
        for (int n = 0; n < 65540; n++) step("sat", 1, 0, 0, 8'hFF, 64'd0);
        check("sat.errs_lit", 64'(err_cnt_o), 64'hFFFF);
        step("sat_more", 1, 1, 0, 8'h01, rdata());
        check("sat_more.errs_lit", 64'(err_cnt_o), 64'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
